// File: rtl/fifo_read_streamer.sv
// rtl/fifo_read_streamer.sv - read-domain FIFO drain engine with 2-entry output buffer and in-flight credit tracking.
// Optional delivered-word counter enabled by defining FIFO_RS_CNT_EN.
module fifo_read_streamer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clkr,
    input  logic             resetr,
    input  logic             enable,
    input  logic             flush,
    input  logic             empty,
    input  logic [WIDTH-1:0] rd,
    output logic             read,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef FIFO_RS_CNT_EN
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] word_cnt
`else
    output logic [WIDTH-1:0] out_data
`endif
);

    logic [WIDTH-1:0] entry [2];
    logic             wr_idx;
    logic             rd_idx;
    logic [1:0]       occ;
    logic             inflight;
    logic             capture;
    logic             pop;

    // A pop is only issued when the buffer can still absorb every word already requested.
    always_comb begin
        read      = ~resetr & enable & ~empty & ~flush &
                    (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
        capture   = inflight & ~flush;
        out_valid = (occ != 2'd0);
        pop       = out_valid & out_ready & ~flush;
        out_data  = entry[rd_idx];
    end

    always_ff @(posedge clkr or posedge resetr) begin
        if (resetr) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_idx   <= 1'b0;
            rd_idx   <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else if (flush) begin
            // The word landing on rd this edge belongs to a dropped pop.
            wr_idx   <= 1'b0;
            rd_idx   <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= read;
            if (capture) begin
                entry[wr_idx] <= rd;
                wr_idx        <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            case ({capture, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_RS_CNT_EN
    always_ff @(posedge clkr or posedge resetr) begin
        if (resetr) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end
`else
    // Keeps the counter width parameter referenced when the counter is compiled out.
    logic [CNT_W-1:0] cnt_unused;
    assign cnt_unused = '0;
`endif

endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb/tb_fifo_read_streamer.sv - self-checking bench for fifo_read_streamer against a queue-based model.
module tb_fifo_read_streamer;

    localparam int W = 32;
`ifdef FIFO_RS_CNT_EN
    localparam int CW = 8;
`else
    localparam int CW = 16;
`endif

    logic          clkr = 1'b0;
    logic          resetr = 1'b0;
    logic          enable = 1'b1;
    logic          flush = 1'b0;
    logic          empty = 1'b1;
    logic [W-1:0]  rd = '0;
    logic          read;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
`ifdef FIFO_RS_CNT_EN
    logic [CW-1:0] word_cnt;
`endif

    always #5 clkr = ~clkr;

    fifo_read_streamer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clkr      (clkr),
        .resetr    (resetr),
        .enable    (enable),
        .flush     (flush),
        .empty     (empty),
        .rd        (rd),
        .read      (read),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FIFO_RS_CNT_EN
        .out_data  (out_data),
        .word_cnt  (word_cnt)
`else
        .out_data  (out_data)
`endif
    );

    int           n_chk = 0;
    int           n_pass = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] src[$];
    logic [W-1:0] delivered[$];
    bit           infl = 0;
    bit           force_empty = 0;
    int           exp_cnt = 0;
    int           garbage = 0;
    logic         l_read, l_valid;
    logic [W-1:0] l_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_src();
        empty = force_empty || (src.size() == 0);
    endtask

    task automatic model_reset();
        q.delete();
        infl = 0;
        exp_cnt = 0;
    endtask

    task automatic cycle();
        bit er, ev, sp;
        @(negedge clkr);
        er = !resetr && enable && !empty && !flush && ((q.size() + (infl ? 1 : 0)) < 2);
        ev = (q.size() != 0);
        l_read = read;
        l_valid = out_valid;
        l_data = out_data;
        chk("read", read, er);
        chk("out_valid", out_valid, ev);
        if (ev) chk("out_data", out_data, q[0]);
`ifdef FIFO_RS_CNT_EN
        chk("word_cnt", word_cnt, exp_cnt[CW-1:0]);
`endif
        sp = ev && out_ready && !flush;
        @(posedge clkr);
        if (resetr) begin
            model_reset();
        end else if (flush) begin
            q.delete();
            infl = 0;
        end else begin
            if (sp) begin
                delivered.push_back(q.pop_front());
                exp_cnt++;
            end
            if (infl) q.push_back(rd);
            infl = er;
        end
        #1;
        if (er) begin
            rd = src.pop_front();
        end else begin
            garbage++;
            rd = 32'hBAD0_0000 | garbage;
        end
        drive_src();
    endtask

    initial begin
        int nr;
        src.push_back(32'h0000_00A1);
        src.push_back(32'h0000_00B2);
        drive_src();
        // Reset asserted mid-cycle with the FIFO non-empty.
        #2 resetr = 1'b1;
        model_reset();
        #1;
        chk("rst_async_read", read, 1'b0);
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_data", out_data, 32'h0);
        repeat (3) begin
            cycle();
            chk("rst_hold_read", l_read, 1'b0);
            chk("rst_hold_data", l_data, 32'h0);
        end
        resetr = 1'b0;
        repeat (8) cycle();
        chk("post_rst_count", delivered.size(), 2);
        if (delivered.size() == 2) begin
            chk("post_rst_w0", delivered[0], 32'h0000_00A1);
            chk("post_rst_w1", delivered[1], 32'h0000_00B2);
        end

        // Single word latency.
        delivered.delete();
        src.push_back(32'hDEADBEEF);
        drive_src();
        cycle(); chk("sw_read_n", l_read, 1'b1);
        cycle(); chk("sw_read_n1", l_read, 1'b0); chk("sw_valid_n1", l_valid, 1'b0);
        cycle(); chk("sw_valid_n2", l_valid, 1'b1); chk("sw_data_n2", l_data, 32'hDEADBEEF);
        cycle(); chk("sw_valid_n3", l_valid, 1'b0);

        // Streaming eight words.
        delivered.delete();
        for (int i = 1; i <= 8; i++) src.push_back(i);
        drive_src();
        repeat (16) cycle();
        chk("stream_count", delivered.size(), 8);
        for (int i = 0; i < delivered.size(); i++) chk("stream_word", delivered[i], i + 1);

        // Backpressure: two pops fill the buffer, then reads stop.
        delivered.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) src.push_back(32'h100 + i);
        drive_src();
        nr = 0;
        repeat (6) begin
            cycle();
            if (l_read) nr++;
        end
        chk("bp_reads", nr, 2);
        chk("bp_valid", l_valid, 1'b1);
        chk("bp_head", l_data, 32'h100);
        out_ready = 1'b1;
        repeat (12) cycle();
        chk("bp_count", delivered.size(), 5);
        for (int i = 0; i < delivered.size(); i++) chk("bp_word", delivered[i], 32'h100 + i);

        // Flush with one buffered word and one in flight, then with a full buffer.
        delivered.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) src.push_back(32'h200 + i);
        drive_src();
        repeat (2) cycle();
        flush = 1'b1;
        cycle(); chk("flush_read", l_read, 1'b0);
        flush = 1'b0;
        cycle(); chk("flush_valid_after", l_valid, 1'b0); chk("flush_read_after", l_read, 1'b1);
        repeat (4) cycle();
        chk("flush2_valid_before", l_valid, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        out_ready = 1'b1;
        src.push_back(32'h300);
        src.push_back(32'h301);
        drive_src();
        repeat (12) cycle();
        chk("flush_count", delivered.size(), 2);
        if (delivered.size() == 2) begin
            chk("flush_w0", delivered[0], 32'h300);
            chk("flush_w1", delivered[1], 32'h301);
        end

        // Enable drop and empty rising while a word is in flight.
        delivered.delete();
        for (int i = 0; i < 4; i++) src.push_back(32'h400 + i);
        drive_src();
        cycle();
        enable = 1'b0;
        repeat (4) cycle();
        chk("en_off_count", delivered.size(), 1);
        enable = 1'b1;
        cycle();
        force_empty = 1;
        drive_src();
        repeat (4) cycle();
        chk("empty_rise_count", delivered.size(), 2);
        force_empty = 0;
        drive_src();
        repeat (10) cycle();
        chk("en_count", delivered.size(), 4);
        for (int i = 0; i < delivered.size(); i++) chk("en_word", delivered[i], 32'h400 + i);

        // Reset mid-stream discards buffered words.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) src.push_back(32'h500 + i);
        drive_src();
        repeat (3) cycle();
        #2 resetr = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_read", read, 1'b0);
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_data", out_data, 32'h0);
        repeat (2) cycle();
        resetr = 1'b0;
        out_ready = 1'b1;
        repeat (12) cycle();

`ifdef FIFO_RS_CNT_EN
        // Counter wrap: 300 handshakes with an 8-bit counter, then a flush.
        #2 resetr = 1'b1;
        model_reset();
        src.delete();
        drive_src();
        repeat (2) cycle();
        resetr = 1'b0;
        for (int i = 0; i < 300; i++) src.push_back(32'h1000 + i);
        drive_src();
        repeat (500) cycle();
        chk("cnt_wrap", word_cnt, 8'd44);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        chk("cnt_after_flush", word_cnt, 8'd44);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
